axi_grid_tx_arbiter: RTL and testbench



---
 rtl/axi_default_param_pkg.sv | 34 +++
 rtl/axi_grid_pkg.sv | 27 ++
 rtl/axi_grid_rr_arbiter.sv | 54 +++++
 rtl/axi_grid_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_axi_grid_tx_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_default_param_pkg.sv
// Default grid channel payload types used when the arbiter is instantiated without overrides.
package axi_default_param_pkg;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } grid_aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } grid_w_chan_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } grid_b_chan_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } grid_ar_chan_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } grid_r_chan_t;

endpackage

// File: rtl/axi_grid_pkg.sv
// Shared definitions for the grid TX link: channel tags and link payload sizing.
package axi_grid_pkg;

  localparam int unsigned GRID_LINK_TAG_W = 3;
  localparam int unsigned GRID_NUM_CHAN   = 5;

  typedef enum logic [GRID_LINK_TAG_W-1:0] {
    TagAw = 3'd0,
    TagW  = 3'd1,
    TagB  = 3'd2,
    TagAr = 3'd3,
    TagR  = 3'd4
  } grid_link_tag_e;

  function automatic int unsigned grid_payload_w(input int unsigned aw_w, input int unsigned w_w,
                                                 input int unsigned b_w, input int unsigned ar_w,
                                                 input int unsigned r_w);
    int unsigned m;
    m = aw_w;
    if (w_w > m) m = w_w;
    if (b_w > m) m = b_w;
    if (ar_w > m) m = ar_w;
    if (r_w > m) m = r_w;
    return m;
  endfunction

endpackage

// File: rtl/axi_grid_rr_arbiter.sv
// N-request round-robin arbiter with an optional lock that restricts eligibility to one index.
module axi_grid_rr_arbiter #(
  parameter int unsigned  N    = 5,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic [N-1:0]    req_i,
  input  logic            lock_valid_i,
  input  logic [IdxW-1:0] lock_idx_i,
  input  logic            advance_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW:0]   cand;
  logic            found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    if (lock_valid_i) begin
      // A locked channel that drops valid gets no grant; nobody else may fill the gap.
      if (req_i[lock_idx_i]) begin
        gnt_o[lock_idx_i] = 1'b1;
        gnt_idx_o         = lock_idx_i;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        cand = {1'b0, ptr_q} + (IdxW + 1)'(i);
        if (cand >= (IdxW + 1)'(N)) cand = cand - (IdxW + 1)'(N);
        if (!found && req_i[cand[IdxW-1:0]]) begin
          found                   = 1'b1;
          gnt_o[cand[IdxW-1:0]] = 1'b1;
          gnt_idx_o               = cand[IdxW-1:0];
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = (gnt_idx_o == IdxW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_grid_tx_arbiter.sv
// Merges the five NI grid channels onto one tagged link through a single output register.
// Optional stall counter ports are enabled with AXI_GRID_TX_ARB_STATS_EN.
module axi_grid_tx_arbiter
  import axi_grid_pkg::*;
#(
  parameter type grid_aw_chan_t = axi_default_param_pkg::grid_aw_chan_t,
  parameter type grid_w_chan_t  = axi_default_param_pkg::grid_w_chan_t,
  parameter type grid_b_chan_t  = axi_default_param_pkg::grid_b_chan_t,
  parameter type grid_ar_chan_t = axi_default_param_pkg::grid_ar_chan_t,
  parameter type grid_r_chan_t  = axi_default_param_pkg::grid_r_chan_t,
  localparam int unsigned PAYLOAD_W = grid_payload_w($bits(grid_aw_chan_t), $bits(grid_w_chan_t),
      $bits(grid_b_chan_t), $bits(grid_ar_chan_t), $bits(grid_r_chan_t))
) (
  input  logic                                 clk_i,
  input  logic                                 arst_i,
  input  grid_aw_chan_t                        aw_i,
  input  logic                                 aw_valid_i,
  output logic                                 aw_ready_o,
  input  grid_w_chan_t                         w_i,
  input  logic                                 w_valid_i,
  output logic                                 w_ready_o,
  input  grid_b_chan_t                         b_i,
  input  logic                                 b_valid_i,
  output logic                                 b_ready_o,
  input  grid_ar_chan_t                        ar_i,
  input  logic                                 ar_valid_i,
  output logic                                 ar_ready_o,
  input  grid_r_chan_t                         r_i,
  input  logic                                 r_valid_i,
  output logic                                 r_ready_o,
  output logic [GRID_LINK_TAG_W+PAYLOAD_W-1:0] link_flit_o,
  output logic                                 link_valid_o,
`ifdef AXI_GRID_TX_ARB_STATS_EN
  input  logic                                 stat_clr_i,
  output logic [15:0]                          stat_stall_o,
`endif
  input  logic                                 link_ready_i
);

  logic [GRID_NUM_CHAN-1:0]   req, gnt, rdy;
  logic [GRID_LINK_TAG_W-1:0] gnt_idx, lock_idx;
  logic                       load_en, xfer, advance, last_beat, lock_valid;
  logic                       w_lock_q, w_lock_d, r_lock_q, r_lock_d;
  logic [PAYLOAD_W-1:0]       payload;
  logic [GRID_LINK_TAG_W+PAYLOAD_W-1:0] flit_q;
  logic                       valid_q;

  assign load_en    = !valid_q | link_ready_i;
  assign req        = {r_valid_i, ar_valid_i, b_valid_i, w_valid_i, aw_valid_i};
  assign lock_valid = w_lock_q | r_lock_q;
  assign lock_idx   = r_lock_q ? TagR : TagW;

  axi_grid_rr_arbiter #(
    .N (GRID_NUM_CHAN)
  ) u_rr_arbiter (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .req_i        (req),
    .lock_valid_i (lock_valid),
    .lock_idx_i   (lock_idx),
    .advance_i    (advance),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx)
  );

  assign rdy        = gnt & {GRID_NUM_CHAN{load_en & !arst_i}};
  assign aw_ready_o = rdy[0];
  assign w_ready_o  = rdy[1];
  assign b_ready_o  = rdy[2];
  assign ar_ready_o = rdy[3];
  assign r_ready_o  = rdy[4];
  assign xfer       = |rdy;

  always_comb begin
    payload   = '0;
    last_beat = 1'b1;
    unique case (grid_link_tag_e'(gnt_idx))
      TagAw: payload[$bits(grid_aw_chan_t)-1:0] = aw_i;
      TagW: begin
        payload[$bits(grid_w_chan_t)-1:0] = w_i;
        last_beat                         = w_i.last;
      end
      TagB:  payload[$bits(grid_b_chan_t)-1:0] = b_i;
      TagAr: payload[$bits(grid_ar_chan_t)-1:0] = ar_i;
      TagR: begin
        payload[$bits(grid_r_chan_t)-1:0] = r_i;
        last_beat                         = r_i.last;
      end
      default: payload = '0;
    endcase
  end

  // Only a beat that ends a grant moves the round-robin pointer.
  assign advance = xfer & last_beat;

  always_comb begin
    w_lock_d = w_lock_q;
    r_lock_d = r_lock_q;
    if (xfer && gnt_idx == TagW) w_lock_d = !w_i.last;
    if (xfer && gnt_idx == TagR) r_lock_d = !r_i.last;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_q  <= 1'b0;
      flit_q   <= '0;
      w_lock_q <= 1'b0;
      r_lock_q <= 1'b0;
    end else begin
      w_lock_q <= w_lock_d;
      r_lock_q <= r_lock_d;
      if (load_en) begin
        valid_q <= xfer;
        if (xfer) flit_q <= {gnt_idx, payload};
      end
    end
  end

  assign link_valid_o = valid_q;
  assign link_flit_o  = flit_q;

`ifdef AXI_GRID_TX_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      stall_cnt_q <= '0;
    end else if (stat_clr_i) begin
      stall_cnt_q <= '0;
    end else if (valid_q && !link_ready_i && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stat_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axi_grid_tx_arbiter.sv
// Directed bench for axi_grid_tx_arbiter: grant order, burst locking, backpressure and reset.
module tb_axi_grid_tx_arbiter;

  localparam logic [47:0] AWV = {8'h11, 32'hA000_0000, 8'h03};
  localparam logic [36:0] WV  = {32'hDEAD_BEEF, 4'hF, 1'b1};
  localparam logic [9:0]  BV  = {8'h22, 2'b01};
  localparam logic [47:0] ARV = {8'h33, 32'hB000_0000, 8'h07};
  localparam logic [42:0] RV  = {8'h44, 32'hCAFE_F00D, 2'b00, 1'b1};

  logic clk, arst;
  axi_default_param_pkg::grid_aw_chan_t aw_i;
  axi_default_param_pkg::grid_w_chan_t  w_i;
  axi_default_param_pkg::grid_b_chan_t  b_i;
  axi_default_param_pkg::grid_ar_chan_t ar_i;
  axi_default_param_pkg::grid_r_chan_t  r_i;
  logic aw_valid, w_valid, b_valid, ar_valid, r_valid;
  logic aw_ready, w_ready, b_ready, ar_ready, r_ready;
  logic [50:0] link_flit;
  logic link_valid, link_ready;
  logic [4:0] rdy;
  int n_tests, n_fail;
`ifdef AXI_GRID_TX_ARB_STATS_EN
  logic stat_clr;
  logic [15:0] stat_stall;
`endif

  assign rdy = {r_ready, ar_ready, b_ready, w_ready, aw_ready};

  axi_grid_tx_arbiter dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .aw_i         (aw_i),
    .aw_valid_i   (aw_valid),
    .aw_ready_o   (aw_ready),
    .w_i          (w_i),
    .w_valid_i    (w_valid),
    .w_ready_o    (w_ready),
    .b_i          (b_i),
    .b_valid_i    (b_valid),
    .b_ready_o    (b_ready),
    .ar_i         (ar_i),
    .ar_valid_i   (ar_valid),
    .ar_ready_o   (ar_ready),
    .r_i          (r_i),
    .r_valid_i    (r_valid),
    .r_ready_o    (r_ready),
    .link_flit_o  (link_flit),
    .link_valid_o (link_valid),
`ifdef AXI_GRID_TX_ARB_STATS_EN
    .stat_clr_i   (stat_clr),
    .stat_stall_o (stat_stall),
`endif
    .link_ready_i (link_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [50:0] exp_flit(input int t);
    case (t)
      0:       return {3'd0, AWV};
      1:       return {3'd1, 11'd0, WV};
      2:       return {3'd2, 38'd0, BV};
      3:       return {3'd3, ARV};
      default: return {3'd4, 5'd0, RV};
    endcase
  endfunction

  initial begin
    logic [36:0] wb;
    logic [42:0] rb;
    n_tests = 0;
    n_fail  = 0;
    arst = 1'b1;
    link_ready = 1'b1;
    aw_valid = 1'b0; w_valid = 1'b0; b_valid = 1'b0; ar_valid = 1'b0; r_valid = 1'b0;
    aw_i = AWV; w_i = WV; b_i = BV; ar_i = ARV; r_i = RV;
`ifdef AXI_GRID_TX_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset: outputs clear, readies held low even with a valid request.
    aw_valid = 1'b1;
    #1;
    check("rst_ready", 64'(rdy), 64'h0);
    check("rst_valid", 64'(link_valid), 64'h0);
    check("rst_flit", 64'(link_flit), 64'h0);
    step(); step();
    arst = 1'b0;

    // Single AW: ready in cycle 0, flit one cycle later.
    #1 check("aw_ready", 64'(rdy), 64'b00001);
    step();
    check("aw_valid", 64'(link_valid), 64'h1);
    check("aw_flit", 64'(link_flit), 64'(exp_flit(0)));

    // No requests: OREG drains, no readies.
    aw_valid = 1'b0;
    #1 check("idle_ready", 64'(rdy), 64'h0);
    step();
    check("idle_valid", 64'(link_valid), 64'h0);

    // Pointer sits at W after the AW grant.
    aw_valid = 1'b1; w_valid = 1'b1;
    #1 check("ptr_w_ready", 64'(rdy), 64'b00010);
    step();
    check("ptr_w_flit", 64'(link_flit), 64'(exp_flit(1)));

    // All five valid: round-robin continues from B, one flit per cycle.
    b_valid = 1'b1; ar_valid = 1'b1; r_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("rr_ready_%0d", k), 64'(rdy), 64'(5'b00001 << ((2 + k) % 5)));
      step();
      check($sformatf("rr_valid_%0d", k), 64'(link_valid), 64'h1);
      check($sformatf("rr_flit_%0d", k), 64'(link_flit), 64'(exp_flit((2 + k) % 5)));
    end
    aw_valid = 1'b0; w_valid = 1'b0; b_valid = 1'b0; ar_valid = 1'b0; r_valid = 1'b0;
    step();
    check("rr_drain_valid", 64'(link_valid), 64'h0);

    // Lone R beat from pointer AR; pointer wraps to AW afterwards.
    r_valid = 1'b1;
    #1 check("r_single_ready", 64'(rdy), 64'b10000);
    step();
    check("r_single_flit", 64'(link_flit), 64'(exp_flit(4)));
    r_valid = 1'b0;

    // W burst of four with AR waiting; one bubble where W drops valid mid-burst.
    w_valid = 1'b1; ar_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        w_valid = 1'b0;
        #1 check("lock_bubble_ready", 64'(rdy), 64'h0);
        step();
        check("lock_bubble_valid", 64'(link_valid), 64'h0);
        w_valid = 1'b1;
      end
      wb  = {32'h100 + 32'(b), 4'hF, (b == 3)};
      w_i = wb;
      #1 check($sformatf("wburst_ready_%0d", b), 64'(rdy), 64'b00010);
      step();
      check($sformatf("wburst_flit_%0d", b), 64'(link_flit), 64'({3'd1, 11'd0, wb}));
    end
    w_valid = 1'b0;
    #1 check("ar_after_burst_ready", 64'(rdy), 64'b01000);
    step();
    check("ar_after_burst_flit", 64'(link_flit), 64'(exp_flit(3)));
    ar_valid = 1'b0;

    // Backpressure: held flit stays stable, no readies, then drains into next grant.
    aw_valid = 1'b1;
    #1 check("bp_aw_ready", 64'(rdy), 64'b00001);
    step();
    check("bp_aw_flit", 64'(link_flit), 64'(exp_flit(0)));
    aw_valid = 1'b0; b_valid = 1'b1; link_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("bp_ready_%0d", c), 64'(rdy), 64'h0);
      step();
      check($sformatf("bp_hold_valid_%0d", c), 64'(link_valid), 64'h1);
      check($sformatf("bp_hold_flit_%0d", c), 64'(link_flit), 64'(exp_flit(0)));
    end
    link_ready = 1'b1;
    #1 check("bp_release_ready", 64'(rdy), 64'b00100);
    step();
    check("bp_next_flit", 64'(link_flit), 64'(exp_flit(2)));
    b_valid = 1'b0;
    step();
    check("bp_drain_valid", 64'(link_valid), 64'h0);

    // Reset during beat 3 of an R burst; AW wins afterwards.
    r_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      rb  = {8'h44, 32'h200 + 32'(b), 2'b00, 1'b0};
      r_i = rb;
      #1 check($sformatf("rburst_ready_%0d", b), 64'(rdy), 64'b10000);
      step();
      check($sformatf("rburst_flit_%0d", b), 64'(link_flit), 64'({3'd4, 5'd0, rb}));
    end
    r_i = {8'h44, 32'h202, 2'b00, 1'b0};
    aw_valid = 1'b1;
    #1 check("rlock_starve_ready", 64'(rdy), 64'b10000);
    arst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(link_valid), 64'h0);
    check("rst_mid_ready", 64'(rdy), 64'h0);
    step();
    arst = 1'b0;
    #1 check("post_rst_ready", 64'(rdy), 64'b00001);
    step();
    check("post_rst_flit", 64'(link_flit), 64'(exp_flit(0)));
    aw_valid = 1'b0; r_valid = 1'b0;
    step();

`ifdef AXI_GRID_TX_ARB_STATS_EN
    check("stat_start", 64'(stat_stall), 64'h0);
    link_ready = 1'b0;
    aw_valid = 1'b1;
    step();
    aw_valid = 1'b0;
    check("stat_load", 64'(stat_stall), 64'h0);
    repeat (5) step();
    check("stat_five", 64'(stat_stall), 64'd5);
    stat_clr = 1'b1;
    step();
    check("stat_clr", 64'(stat_stall), 64'h0);
    stat_clr = 1'b0;
    repeat (70000) @(posedge clk);
    #1 check("stat_sat", 64'(stat_stall), 64'hFFFF);
    link_ready = 1'b1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
